// File: rtl/cache_nway_pkg.sv
// Shared LC-3b memory types and the cache controller state encoding.
package cache_nway_pkg;

    typedef logic [255:0] lc3b_burst;
    typedef logic [15:0]  lc3b_word;

    localparam int OFFSET_W   = 5;
    localparam int WORD_SEL_W = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITEBACK,
        S_ALLOCATE,
        S_FLUSH_SCAN,
        S_FLUSH_WB
    } cache_state_e;

endpackage

// File: rtl/cache_nway_plru_tree.sv
// Tree pseudo-LRU for one set. Node n (heap order, root = 1) is bit n-1.
// A node bit of 0 sends the victim search to the lower half, 1 to the upper half.
module plru_tree #(
    parameter  int WAYS   = 4,
    localparam int WAY_W  = $clog2(WAYS),
    localparam int PLRU_W = WAYS - 1
) (
    input  logic [PLRU_W-1:0] plru_state,
    input  logic [WAY_W-1:0]  access_way,
    output logic [WAY_W-1:0]  victim_way,
    output logic [PLRU_W-1:0] plru_next
);

    int                vnode;
    logic [PLRU_W-1:0] v_sh;
    int                unode;
    logic [WAY_W-1:0]  a_sh;
    logic [PLRU_W-1:0] u_mask;

    // Follow the node bits from the root down to a leaf; leaf node - WAYS is the victim.
    always_comb begin
        vnode = 1;
        v_sh  = '0;
        for (int l = 0; l < WAY_W; l++) begin
            v_sh  = plru_state >> (vnode - 1);
            vnode = 2 * vnode + int'(v_sh[0]);
        end
        victim_way = WAY_W'(vnode - WAYS);
    end

    // Walk the accessed way's path and point every node on it at the other half.
    always_comb begin
        plru_next = plru_state;
        unode     = 1;
        a_sh      = '0;
        u_mask    = '0;
        for (int l = WAY_W - 1; l >= 0; l--) begin
            a_sh   = access_way >> l;
            u_mask = PLRU_W'(1) << (unode - 1);
            if (a_sh[0]) plru_next = plru_next & ~u_mask;
            else         plru_next = plru_next | u_mask;
            unode  = 2 * unode + int'(a_sh[0]);
        end
    end

endmodule

// File: rtl/cache_nway.sv
// N-way set-associative write-back, write-allocate L1 cache with tree PLRU and flush engine.
// state        | meaning
// S_IDLE       | serve hits, pick victim on miss, accept flush_req
// S_WRITEBACK  | burst dirty victim line out to physical memory
// S_ALLOCATE   | burst requested line in, install into victim way
// S_FLUSH_SCAN | step {set, way} counter looking for dirty lines
// S_FLUSH_WB   | burst the dirty line found by the scan, then clean it
module cache_nway
    import cache_nway_pkg::*;
#(
    parameter int WAYS = 4,
    parameter int SETS = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            mem_read,
    input  logic            mem_write,
    input  logic [1:0]      mem_byte_enable,
    input  logic [15:0]     mem_address,
    input  logic [15:0]     mem_wdata,
    output logic [15:0]     mem_rdata,
    output logic            mem_resp,
    input  logic            flush_req,
    output logic            flush_done,
    output logic            pmem_read,
    output logic            pmem_write,
    output logic [15:0]     pmem_address,
    output logic [255:0]    pmem_wdata,
    input  logic [255:0]    pmem_rdata,
    input  logic            pmem_resp
);

    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = 16 - OFFSET_W - IDX_W;
    localparam int PLRU_W = WAYS - 1;
    localparam int WAY_W  = $clog2(WAYS);
    localparam int ENT_W  = IDX_W + WAY_W;
    localparam int CNT_W  = ENT_W + 1;

    cache_state_e state_q, state_d;

    lc3b_burst         data_arr [SETS][WAYS];
    logic [TAG_W-1:0]  tag_arr  [SETS][WAYS];
    logic [WAYS-1:0]   valid_q  [SETS];
    logic [WAYS-1:0]   dirty_q  [SETS];
    logic [PLRU_W-1:0] plru_q   [SETS];

    logic [WAY_W-1:0]  victim_q;
    logic [CNT_W-1:0]  scan_q;

    logic [TAG_W-1:0]      req_tag;
    logic [IDX_W-1:0]      req_idx;
    logic [WORD_SEL_W-1:0] req_word;
    logic                  addr_unused;

    logic [WAYS-1:0]  hit_vec;
    logic             hit;
    logic [WAY_W-1:0] hit_way;
    logic             inv_found;
    logic [WAY_W-1:0] inv_way;
    logic [WAY_W-1:0] victim_sel;
    logic [WAY_W-1:0] plru_victim;
    logic [WAY_W-1:0] plru_access;
    logic [PLRU_W-1:0] plru_next;

    lc3b_burst hit_line;
    lc3b_burst rd_line_sh;
    lc3b_burst wmask;
    lc3b_burst wdat;
    lc3b_burst merged;
    logic [7:0] word_shift;

    logic [IDX_W-1:0] scan_set;
    logic [WAY_W-1:0] scan_way;
    logic             scan_end;

    logic do_write_hit, do_fill, plru_upd, miss_latch, scan_clr, scan_inc, wb_clean;

    assign req_tag     = mem_address[15:OFFSET_W+IDX_W];
    assign req_idx     = mem_address[OFFSET_W+IDX_W-1:OFFSET_W];
    assign req_word    = mem_address[OFFSET_W-1:1];
    assign addr_unused = mem_address[0];

    assign scan_set = scan_q[ENT_W-1:WAY_W];
    assign scan_way = scan_q[WAY_W-1:0];
    assign scan_end = scan_q[ENT_W];

    // Per-way tag compare in the addressed set.
    for (genvar w = 0; w < WAYS; w++) begin : g_way
        assign hit_vec[w] = valid_q[req_idx][w] && (tag_arr[req_idx][w] == req_tag);
    end

    assign hit = |hit_vec;

    // Encode the hitting way and the lowest-index invalid way.
    always_comb begin
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (hit_vec[WAY_W'(w)]) hit_way = WAY_W'(w);
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[req_idx][WAY_W'(w)]) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
        end
    end

    assign victim_sel  = inv_found ? inv_way : plru_victim;
    assign plru_access = (state_q == S_ALLOCATE) ? victim_q : hit_way;

    plru_tree #(.WAYS(WAYS)) u_plru (
        .plru_state (plru_q[req_idx]),
        .access_way (plru_access),
        .victim_way (plru_victim),
        .plru_next  (plru_next)
    );

    // Word read-out and byte-lane merge for the hit line.
    always_comb begin
        word_shift = {req_word, 4'b0000};
        hit_line   = data_arr[req_idx][hit_way];
        rd_line_sh = hit_line >> word_shift;
        wmask      = {240'b0, {8{mem_byte_enable[1]}}, {8{mem_byte_enable[0]}}} << word_shift;
        wdat       = {240'b0, mem_wdata} << word_shift;
        merged     = (hit_line & ~wmask) | (wdat & wmask);
    end

    assign mem_rdata = rd_line_sh[15:0];

    // Next-state and output decode.
    always_comb begin
        state_d      = state_q;
        mem_resp     = 1'b0;
        flush_done   = 1'b0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        do_write_hit = 1'b0;
        do_fill      = 1'b0;
        plru_upd     = 1'b0;
        miss_latch   = 1'b0;
        scan_clr     = 1'b0;
        scan_inc     = 1'b0;
        wb_clean     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (mem_read || mem_write) begin
                    if (hit) begin
                        mem_resp     = 1'b1;
                        plru_upd     = 1'b1;
                        do_write_hit = mem_write;
                    end else begin
                        miss_latch = 1'b1;
                        if (valid_q[req_idx][victim_sel] && dirty_q[req_idx][victim_sel])
                            state_d = S_WRITEBACK;
                        else
                            state_d = S_ALLOCATE;
                    end
                end else if (flush_req) begin
                    scan_clr = 1'b1;
                    state_d  = S_FLUSH_SCAN;
                end
            end
            S_WRITEBACK: begin
                pmem_write   = 1'b1;
                pmem_address = {tag_arr[req_idx][victim_q], req_idx, {OFFSET_W{1'b0}}};
                pmem_wdata   = data_arr[req_idx][victim_q];
                if (pmem_resp) state_d = S_ALLOCATE;
            end
            S_ALLOCATE: begin
                pmem_read    = 1'b1;
                pmem_address = {req_tag, req_idx, {OFFSET_W{1'b0}}};
                if (pmem_resp) begin
                    do_fill  = 1'b1;
                    plru_upd = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            S_FLUSH_SCAN: begin
                if (scan_end) begin
                    flush_done = 1'b1;
                    state_d    = S_IDLE;
                end else if (valid_q[scan_set][scan_way] && dirty_q[scan_set][scan_way]) begin
                    state_d = S_FLUSH_WB;
                end else begin
                    scan_inc = 1'b1;
                end
            end
            S_FLUSH_WB: begin
                pmem_write   = 1'b1;
                pmem_address = {tag_arr[scan_set][scan_way], scan_set, {OFFSET_W{1'b0}}};
                pmem_wdata   = data_arr[scan_set][scan_way];
                if (pmem_resp) begin
                    wb_clean = 1'b1;
                    scan_inc = 1'b1;
                    state_d  = S_FLUSH_SCAN;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control registers: state, latched victim way, flush scan counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            victim_q <= '0;
            scan_q   <= '0;
        end else begin
            state_q <= state_d;
            if (miss_latch) victim_q <= victim_sel;
            if (scan_clr)      scan_q <= '0;
            else if (scan_inc) scan_q <= scan_q + 1'b1;
        end
    end

    // Valid, dirty and PLRU metadata; cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '{default: '0};
            dirty_q <= '{default: '0};
            plru_q  <= '{default: '0};
        end else begin
            if (do_write_hit) dirty_q[req_idx][hit_way] <= 1'b1;
            if (do_fill) begin
                valid_q[req_idx][victim_q] <= 1'b1;
                dirty_q[req_idx][victim_q] <= 1'b0;
            end
            if (wb_clean) dirty_q[scan_set][scan_way] <= 1'b0;
            if (plru_upd) plru_q[req_idx] <= plru_next;
        end
    end

    // Line data and tags; contents are meaningless until valid, so no reset.
    always_ff @(posedge clk) begin
        if (do_write_hit) begin
            data_arr[req_idx][hit_way] <= merged;
        end else if (do_fill) begin
            data_arr[req_idx][victim_q] <= pmem_rdata;
            tag_arr[req_idx][victim_q]  <= req_tag;
        end
    end

endmodule
